step_period_meter: RTL

Measures the half-period of an incoming step/clock square wave, such as the output of the motor clock divider, in system-clock cycles. It reports the count on every edge of the input, so the value equals the `count_to` setting that produced the waveform. It also flags a stalled input and reports whether the measurement matches an expected `count_to`. It sits on the monitor side of the step-motor path, closing the loop on the divider so firmware and the bench can confirm the motor step rate.

---
 rtl/step_period_meter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/step_period_meter.sv
// step_period_meter: measures the half-period of an asynchronous square wave
// in clk cycles, flags a stalled input and compares the measurement against an
// expected half-period.
module step_period_meter #(
  parameter logic [20:0] TIMEOUT = 21'h1FFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_in,
  input  logic [20:0] count_to,
  output logic [20:0] period,
  output logic        period_valid,
  output logic        match,
  output logic        stalled
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // The counter sits at TIMEOUT-1 in the last cycle before a stall is declared.
  localparam logic [20:0] TIMEOUT_M1 = TIMEOUT - 21'd1;

  state_t      state_q, state_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        s3_q, s3_d;
  logic [20:0] cnt_q, cnt_d;
  logic [20:0] period_q, period_d;
  logic        period_valid_q, period_valid_d;
  logic        match_q, match_d;
  logic        stalled_q, stalled_d;

  logic        edge_det;
  logic [20:0] cnt_inc;

  // Synchronizer chain plus one extra stage for edge detection.
  always_comb begin
    s1_d = step_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign edge_det = s2_q ^ s3_q;
  // cnt never exceeds TIMEOUT-1, so the increment cannot overflow 21 bits.
  assign cnt_inc  = cnt_q + 21'd1;

  // Next-state and measurement logic; the edge is checked before the timeout
  // so a coincident edge always produces a measurement instead of a stall.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    stalled_d      = stalled_q;
    match_d        = (period_q != 21'd0) && (period_q == count_to);

    case (state_q)
      IDLE: begin
        cnt_d = 21'd0;
        if (edge_det) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (edge_det) begin
          period_d       = cnt_inc;
          period_valid_d = 1'b1;
          stalled_d      = 1'b0;
          match_d        = (cnt_inc == count_to);
          cnt_d          = 21'd0;
        end else if (cnt_q == TIMEOUT_M1) begin
          state_d   = IDLE;
          stalled_d = 1'b1;
          period_d  = 21'd0;
          match_d   = 1'b0;
          cnt_d     = 21'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 21'd0;
      end
    endcase
  end

  // State register; every flop clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      cnt_q          <= 21'd0;
      period_q       <= 21'd0;
      period_valid_q <= 1'b0;
      match_q        <= 1'b0;
      stalled_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      match_q        <= match_d;
      stalled_q      <= stalled_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign match        = match_q;
  assign stalled      = stalled_q;

endmodule
